// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, stores opcodes,
// pads the rest of program memory with zeros after the terminator.
module uart_prog_loader #(
  parameter int         PROG_ADDR_WIDTH = 14,
  parameter int         PROG_LEN        = 16383,
  parameter int         CLKS_PER_BIT    = 104,
  parameter logic [7:0] TERM_BYTE       = 8'h21
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       load_req,
  input  logic                       uart_rx,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       loading,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int AW = PROG_ADDR_WIDTH;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   LEN  = (AW + 1)'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_WAIT,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_WRITE,
    S_PAD,
    S_DONE
  } state_e;

  state_e          state_q;
  logic            rx_meta_q;
  logic            rx_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [AW:0]     wptr_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      wr_q;
  logic            loaded_q;
  logic            ovf_q;
  logic            ferr_q;

  function automatic logic is_op(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      8'h2B, 8'h2D, 8'h3C, 8'h3E,
      8'h2E, 8'h2C, 8'h5B, 8'h5D: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wptr_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wr_q      <= '0;
      loaded_q  <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_q      <= rx_meta_q;
      we_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load_req) begin
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            wptr_q   <= '0;
            state_q  <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (!rx_q) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_RX_START;
          end
        end
        S_RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            state_q <= rx_q ? S_RX_WAIT : S_RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RX_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (rx_q) begin
              state_q <= S_WRITE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_RX_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_RX_WAIT;
          if (shift_q == TERM_BYTE) begin
            state_q <= S_PAD;
          end else if (is_op(shift_q)) begin
            if (wptr_q < LEN) begin
              we_q   <= 1'b1;
              addr_q <= wptr_q[AW-1:0];
              wr_q   <= shift_q;
              wptr_q <= wptr_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (wptr_q < LEN) begin
            we_q   <= 1'b1;
            addr_q <= wptr_q[AW-1:0];
            wr_q   <= 8'h00;
            wptr_q <= wptr_q + 1'b1;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          loaded_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prog_we   = we_q;
  assign prog_addr = addr_q;
  assign prog_wr   = wr_q;
  assign loaded    = loaded_q;
  assign loading   = (state_q != S_IDLE);
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: serial byte stimulus,
// expected write stream derived from a byte-list reference model.
module tb_uart_prog_loader;

  localparam int CPB = 16;
  localparam int LEN = 16;
  localparam int AW  = 4;
  localparam logic [7:0] TERM = 8'h21;

  logic          clk;
  logic          resetn;
  logic          load_req;
  logic          uart_rx;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_wr;
  logic          loaded;
  logic          loading;
  logic          overflow;
  logic          frame_err;

  uart_prog_loader #(
    .PROG_ADDR_WIDTH(AW),
    .PROG_LEN       (LEN),
    .CLKS_PER_BIT   (CPB),
    .TERM_BYTE      (TERM)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .load_req (load_req),
    .uart_rx  (uart_rx),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_wr  (prog_wr),
    .loaded   (loaded),
    .loading  (loading),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_b[$];
  bit         tx_bad[$];
  bit         tx_gl[$];
  int         tx_gap[$];
  bit         exp_ov;
  bit         exp_fe;
  int         n_vec = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && prog_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write actual=%0d:%h required=none",
                 prog_addr, prog_wr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (prog_addr !== e.a || prog_wr !== e.d) begin
          n_err++;
          $display("FAIL write actual=%0d:%h required=%0d:%h",
                   prog_addr, prog_wr, e.a, e.d);
        end
      end
    end
  end

  function automatic bit opcode(input logic [7:0] b);
    return b inside {"+", "-", "<", ">", ".", ",", "[", "]"};
  endfunction

  // Reference model: walk the byte list and predict every write.
  task automatic build_expect();
    int   n;
    wr_t  w;
    n      = 0;
    exp_ov = 0;
    exp_fe = 0;
    for (int i = 0; i < tx_b.size(); i++) begin
      if (tx_bad[i]) begin
        exp_fe = 1;
      end else if (tx_b[i] == TERM) begin
        break;
      end else if (opcode(tx_b[i])) begin
        if (n < LEN) begin
          w.a = AW'(n);
          w.d = tx_b[i];
          exp_q.push_back(w);
          n++;
        end else begin
          exp_ov = 1;
        end
      end
    end
    for (int a = n; a < LEN; a++) begin
      w.a = AW'(a);
      w.d = 8'h00;
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_tx();
    tx_b.delete();
    tx_bad.delete();
    tx_gl.delete();
    tx_gap.delete();
  endtask

  task automatic add_byte(input logic [7:0] b, input bit bad,
                          input bit gl, input int gap);
    tx_b.push_back(b);
    tx_bad.push_back(bad);
    tx_gl.push_back(gl);
    tx_gap.push_back(gap);
  endtask

  task automatic set_str(input string s);
    clear_tx();
    for (int i = 0; i < s.len(); i++) add_byte(s[i], 0, 0, 0);
  endtask

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(!bad, CPB);
    uart_rx = 1'b1;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("start_loading", loading, 1);
    chk("start_loaded", loaded, 0);
    chk("start_ovf", overflow, 0);
    chk("start_ferr", frame_err, 0);
    build_expect();
  endtask

  task automatic send_all(input bit poke);
    for (int i = 0; i < tx_b.size(); i++) begin
      drive(1'b1, tx_gap[i]);
      if (tx_gl[i]) begin
        drive(1'b0, CPB / 4);
        drive(1'b1, 2 * CPB);
      end
      load_req = poke && (i + 1 < tx_b.size());
      send_byte(tx_b[i], tx_bad[i]);
      load_req = 1'b0;
      if (tx_bad[i]) drive(1'b1, 2 * CPB);
    end
  endtask

  task automatic finish_load(input string nm);
    int k;
    k = 0;
    while (!loaded && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_loaded"}, loaded, 1);
    chk({nm, "_loading"}, loading, 0);
    chk({nm, "_ovf"}, overflow, exp_ov);
    chk({nm, "_ferr"}, frame_err, exp_fe);
    chk({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_load(input string nm, input bit poke);
    start_load();
    send_all(poke);
    finish_load(nm);
  endtask

  logic [7:0] junk[6] = '{"a", " ", 8'h0A, 8'hFF, 8'h00, "b"};
  logic [7:0] ops[8]  = '{"+", "-", "<", ">", ".", ",", "[", "]"};

  initial begin
    int k;
    logic [7:0] b;
    resetn   = 1'b0;
    load_req = 1'b0;
    uart_rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", prog_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_wr", prog_wr, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_loading", loading, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    set_str("+[->+<]!");
    run_load("bf", 1);
    repeat (20) @(negedge clk);
    chk("loaded_hold", loaded, 1);

    set_str("a+ b\n-!");
    run_load("junk", 0);

    clear_tx();
    add_byte("+", 1, 0, 0);
    add_byte("-", 0, 0, 0);
    add_byte("!", 0, 0, 0);
    run_load("ferr", 0);

    clear_tx();
    add_byte(">", 0, 1, 5);
    add_byte("!", 0, 0, 0);
    run_load("glitch", 0);

    clear_tx();
    for (int i = 0; i < LEN; i++) add_byte("+", 0, 0, 0);
    add_byte("!", 0, 0, 0);
    run_load("full", 0);

    clear_tx();
    for (int i = 0; i < LEN + 1; i++) add_byte(".", 0, 0, 0);
    add_byte("!", 0, 0, 0);
    run_load("ovf", 0);

    for (int r = 0; r < 8; r++) begin
      int nb;
      clear_tx();
      nb = (r == 7) ? 18 : int'($urandom_range(1, 12));
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 3))
          0:       b = junk[$urandom_range(0, 5)];
          1:       b = 8'($urandom);
          default: b = ops[$urandom_range(0, 7)];
        endcase
        if (b == TERM) b = 8'h41;
        add_byte(b, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 40));
      end
      add_byte(TERM, 0, 0, $urandom_range(0, 10));
      run_load("rand", r[0]);
    end

    set_str("!");
    start_load();
    send_all(0);
    k = 0;
    while (!prog_we && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pad_seen", prog_we, 1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_we", prog_we, 0);
    chk("mid_addr", prog_addr, 0);
    chk("mid_wr", prog_wr, 0);
    chk("mid_loaded", loaded, 0);
    chk("mid_loading", loading, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_ferr", frame_err, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    set_str("+.!");
    run_load("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
